weight_loader: RTL and testbench
================================

# weight_loader

Bus initiator that programs the spiking network's weight memory port. It accepts a weight stream over a valid/ready handshake and writes each word to the next weight address. Addresses are generated in layer/neuron/weight order from a latched configuration. An optional per-word read-back check verifies each write. The block sits between the host/DMA path and the network's `mem_addr`/`mem_din`/`mem_wen`/`mem_dout` port.

## Interface
- `WEIGHT_SIZE`, 32, weight word width
- `LAYER_ADDR_WIDTH`, 32, full memory address width
- `NEURON_ADDR_WIDTH`, 28, low address bits below the layer field
- `WEIGHT_ADDR_WIDTH`, 10, low address bits below the neuron field
- `READ_LATENCY`, 1, cycles from a stable `mem_addr` to valid `mem_dout`; must be ≥1

Derived widths:
- LW = `LAYER_ADDR_WIDTH`-`NEURON_ADDR_WIDTH`
- NW = `NEURON_ADDR_WIDTH`-`WEIGHT_ADDR_WIDTH`

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, asynchronous, active-high
- `start` in 1: begin a load; sampled only in IDLE
- `cfg_layer` in LW: target layer
- `cfg_num_neurons` in NW+1: neurons to load
- `cfg_num_inputs` in `WEIGHT_ADDR_WIDTH`+1: weights per neuron
- `cfg_verify` in 1: enable read-back check
- `s_valid` in 1: weight stream valid
- `s_data` in `WEIGHT_SIZE`: weight word
- `s_ready` out 1: weight stream ready
- `mem_addr` out `LAYER_ADDR_WIDTH`: memory address
- `mem_din` out `WEIGHT_SIZE`: write data
- `mem_wen` out 1: write enable
- `mem_dout` in `WEIGHT_SIZE`: read data
- `busy` out 1: load in progress
- `done` out 1: one-cycle completion pulse
- `err` out 1: sticky verify mismatch
- `err_addr` out `LAYER_ADDR_WIDTH`: address of the first mismatch

## Operation
- **Reset values:** all outputs reset to 0. State goes to IDLE and all counters clear.
- **Configuration:** `start` in IDLE latches the `cfg_*` inputs. The same edge clears `err` and `err_addr`. `start` while busy is ignored.
- **Zero-size load:** if `cfg_num_neurons`==0 or `cfg_num_inputs`==0, go straight to DONE. No writes occur.
- **Address format:** `mem_addr` = {layer, neuron_idx[NW-1:0], weight_idx[`WEIGHT_ADDR_WIDTH`-1:0]}.
- **Address order:** weight_idx increments fastest. At `cfg_num_inputs`-1 it wraps to 0 and neuron_idx increments. The last word is neuron `cfg_num_neurons`-1, weight `cfg_num_inputs`-1.
- **IDLE:** `busy`=0, `s_ready`=0.
- **WRITE:** `s_ready`=1. On `s_valid`&`s_ready`, register `mem_addr`, `mem_din`=`s_data` and `mem_wen`=1 for exactly the next cycle, then advance the counters.
  - Verify off: stay in WRITE; after the last word go to DONE.
  - Verify on: go to VERIFY.
- **VERIFY:** `s_ready`=0, `mem_wen`=0, `mem_addr` held.
  - Wait `READ_LATENCY` cycles after the write cycle, then compare `mem_dout` to the held data.
  - On mismatch set `err`. Capture `err_addr` only if `err` was 0.
  - The load continues; a mismatch never aborts it.
  - Then return to WRITE, or go to DONE after the last word.
- **DONE:** one cycle with `done`=1 and `busy`=1. Then IDLE with `busy`=0.
- `busy`=1 in every state except IDLE.
- **Reset mid-load:** immediate abort. No `done` pulse; `mem_wen` drops asynchronously.

## Timing
- Handshake accepted at edge N → `mem_wen`=1 during cycle N..N+1 with the matching addr/data.
- Verify off: sustained 1 word/cycle, with `s_ready` held high through WRITE.
- Verify on: 1 word per 2+`READ_LATENCY` cycles. The compare samples `mem_dout` at the edge ending cycle write+`READ_LATENCY`.
- Verify off: `done` is asserted in the cycle immediately after the final `mem_wen` cycle.
- Verify on: `done` is asserted in the cycle after the final compare.
- Zero-size load: `start` at edge N → `done` in cycle N+1..N+2.
- `mem_addr`/`mem_din` hold their last values when `mem_wen`=0.

## Test plan
- **Basic load:** layer=1, 2 neurons × 3 inputs, verify off, `s_valid` always high, data 0xA0..0xA5. Expect writes to 0x10000000/01/02 and 0x10000400/01/02 with matching data on 6 consecutive `mem_wen` cycles. `done` follows the 6th; no `err`.
- **Backpressure:** same config with `s_valid` toggling 1,0,0,1,… Expect exactly 6 `mem_wen` pulses, each one cycle after an accept, with no duplicate or skipped address.
- **Verify, all match:** verify on, `READ_LATENCY`=1, ideal memory model. Expect `s_ready` high once per 3 cycles, `err`=0 and `done` after the 6th compare.
- **Verify, mismatch:** memory model corrupts the 4th and 5th words. Expect `err`=1, `err_addr`=0x10000400 (first mismatch only) and all 6 writes still performed; the next `start` clears `err`.
- **Zero-size load:** `cfg_num_inputs`=0. Expect no `mem_wen`, `s_ready` never high, and `done` in the cycle after `start`.
- **Reset mid-load:** assert `rst` after the 2nd write. Expect all outputs 0 immediately and no `done`; a fresh `start` then restarts from weight 0 of neuron 0.

Source files
------------

// File: rtl/weight_loader.sv
// weight_loader: bus initiator that streams weight words into the spiking
// network's weight memory. Each accepted word is written to the next
// {layer, neuron, weight} address. An optional read-back pass compares each
// written word against mem_dout and records the first failing address.
module weight_loader #(
  parameter int WEIGHT_SIZE       = 32,
  parameter int LAYER_ADDR_WIDTH  = 32,
  parameter int NEURON_ADDR_WIDTH = 28,
  parameter int WEIGHT_ADDR_WIDTH = 10,
  parameter int READ_LATENCY      = 1,
  localparam int LW = LAYER_ADDR_WIDTH - NEURON_ADDR_WIDTH,
  localparam int NW = NEURON_ADDR_WIDTH - WEIGHT_ADDR_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [LW-1:0]                cfg_layer,
  input  logic [NW:0]                  cfg_num_neurons,
  input  logic [WEIGHT_ADDR_WIDTH:0]   cfg_num_inputs,
  input  logic                         cfg_verify,
  input  logic                         s_valid,
  input  logic [WEIGHT_SIZE-1:0]       s_data,
  output logic                         s_ready,
  output logic [LAYER_ADDR_WIDTH-1:0]  mem_addr,
  output logic [WEIGHT_SIZE-1:0]       mem_din,
  output logic                         mem_wen,
  input  logic [WEIGHT_SIZE-1:0]       mem_dout,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic [LAYER_ADDR_WIDTH-1:0]  err_addr
);

  // Width of the read-latency wait counter; always at least one bit.
  localparam int LAT_W = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY + 1);

  // FLUSH is the one-cycle gap between the final write (or a zero-size
  // start) and the done pulse, so that done lands in the following cycle.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_VERIFY,
    ST_FLUSH,
    ST_DONE
  } state_t;

  state_t                       state;

  // Configuration latched at start.
  logic [LW-1:0]                layer_q;
  logic [NW:0]                  num_neurons_q;
  logic [WEIGHT_ADDR_WIDTH:0]   num_inputs_q;
  logic                         verify_q;

  // Address generation counters; weight index runs fastest.
  logic [WEIGHT_ADDR_WIDTH-1:0] wgt_idx;
  logic [NW-1:0]                neu_idx;

  // Set when the word currently being written is the final one.
  logic                         last_q;

  // Cycles spent in VERIFY since the write cycle ended.
  logic [LAT_W-1:0]             lat_cnt;

  logic                         last_wgt;
  logic                         last_neu;
  logic                         accept;

  // Position of the counters relative to the latched load dimensions.
  assign last_wgt = ({1'b0, wgt_idx} ==
                     (num_inputs_q - (WEIGHT_ADDR_WIDTH + 1)'(1)));
  assign last_neu = ({1'b0, neu_idx} == (num_neurons_q - (NW + 1)'(1)));

  // s_ready is registered and only ever high in WRITE.
  assign accept = s_valid & s_ready;

  // Load sequencer: latches config, issues writes, runs read-back, and
  // drives every output from a register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      layer_q       <= '0;
      num_neurons_q <= '0;
      num_inputs_q  <= '0;
      verify_q      <= 1'b0;
      wgt_idx       <= '0;
      neu_idx       <= '0;
      last_q        <= 1'b0;
      lat_cnt       <= '0;
      s_ready       <= 1'b0;
      mem_addr      <= '0;
      mem_din       <= '0;
      mem_wen       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      err_addr      <= '0;
    end else begin
      // NOTE: non-blocking assignments here let every branch below read the
      // pre-edge value of err, wgt_idx and friends regardless of order.
      // Pulses default low; branches raise them for a single cycle.
      mem_wen <= 1'b0;
      done    <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            layer_q       <= cfg_layer;
            num_neurons_q <= cfg_num_neurons;
            num_inputs_q  <= cfg_num_inputs;
            verify_q      <= cfg_verify;
            wgt_idx       <= '0;
            neu_idx       <= '0;
            last_q        <= 1'b0;
            lat_cnt       <= '0;
            err           <= 1'b0;
            err_addr      <= '0;
            busy          <= 1'b1;
            if ((cfg_num_neurons == '0) || (cfg_num_inputs == '0)) begin
              state <= ST_FLUSH;
            end else begin
              state   <= ST_WRITE;
              s_ready <= 1'b1;
            end
          end
        end

        ST_WRITE: begin
          if (accept) begin
            mem_addr <= {layer_q, neu_idx, wgt_idx};
            mem_din  <= s_data;
            mem_wen  <= 1'b1;
            last_q   <= last_wgt & last_neu;
            lat_cnt  <= '0;

            if (last_wgt) begin
              wgt_idx <= '0;
              neu_idx <= neu_idx + NW'(1);
            end else begin
              wgt_idx <= wgt_idx + WEIGHT_ADDR_WIDTH'(1);
            end

            if (verify_q) begin
              state   <= ST_VERIFY;
              s_ready <= 1'b0;
            end else if (last_wgt && last_neu) begin
              state   <= ST_FLUSH;
              s_ready <= 1'b0;
            end
          end
        end

        ST_VERIFY: begin
          // mem_addr and mem_din stay put so the read returns this word.
          if (lat_cnt == LAT_W'(READ_LATENCY)) begin
            if (mem_dout != mem_din) begin
              err <= 1'b1;
              if (!err) begin
                err_addr <= mem_addr;
              end
            end
            if (last_q) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state   <= ST_WRITE;
              s_ready <= 1'b1;
            end
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end

        ST_FLUSH: begin
          state <= ST_DONE;
          done  <= 1'b1;
        end

        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state   <= ST_IDLE;
          s_ready <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_weight_loader.sv
// Directed testbench for weight_loader: plain writes, backpressure,
// read-back with and without corruption, zero-size load and reset abort.
module tb_weight_loader;

  localparam int WS  = 32;
  localparam int LAW = 32;
  localparam int NAW = 28;
  localparam int WAW = 10;
  localparam int RL  = 1;
  localparam int LW  = LAW - NAW;
  localparam int NW  = NAW - WAW;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [LW-1:0]   cfg_layer = '0;
  logic [NW:0]     cfg_num_neurons = '0;
  logic [WAW:0]    cfg_num_inputs = '0;
  logic            cfg_verify = 1'b0;
  logic            s_valid = 1'b0;
  logic [WS-1:0]   s_data = '0;
  logic            s_ready;
  logic [LAW-1:0]  mem_addr;
  logic [WS-1:0]   mem_din;
  logic            mem_wen;
  logic [WS-1:0]   mem_dout = '0;
  logic            busy;
  logic            done;
  logic            err;
  logic [LAW-1:0]  err_addr;

  weight_loader #(
    .WEIGHT_SIZE      (WS),
    .LAYER_ADDR_WIDTH (LAW),
    .NEURON_ADDR_WIDTH(NAW),
    .WEIGHT_ADDR_WIDTH(WAW),
    .READ_LATENCY     (RL)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .cfg_layer      (cfg_layer),
    .cfg_num_neurons(cfg_num_neurons),
    .cfg_num_inputs (cfg_num_inputs),
    .cfg_verify     (cfg_verify),
    .s_valid        (s_valid),
    .s_data         (s_data),
    .s_ready        (s_ready),
    .mem_addr       (mem_addr),
    .mem_din        (mem_din),
    .mem_wen        (mem_wen),
    .mem_dout       (mem_dout),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .err_addr       (err_addr)
  );

  always #5 clk = ~clk;

  // Expected address sequence for layer 1, 2 neurons x 3 inputs.
  logic [31:0] exp_addr [6] = '{32'h1000_0000, 32'h1000_0001, 32'h1000_0002,
                                32'h1000_0400, 32'h1000_0401, 32'h1000_0402};

  int errors = 0;
  int checks = 0;

  // Observations gathered while a load runs.
  logic [31:0] wr_addr [$];
  logic [31:0] wr_data [$];
  int          wr_cyc  [$];
  int          acc_cyc [$];
  int          done_cyc;
  int          done_cnt;
  int          rdy_cnt;

  // Memory model, write-first, one-cycle read latency; optionally returns
  // inverted data for the two words of neuron 1 at weights 0 and 1.
  logic [31:0] mem [16];
  logic        corrupt_en = 1'b0;

  function automatic int mem_idx(input logic [31:0] a);
    return int'({a[10], a[2:0]});
  endfunction

  function automatic logic [31:0] rd_val(input logic [31:0] a, input logic [31:0] v);
    if (corrupt_en && (a == 32'h1000_0400 || a == 32'h1000_0401)) return ~v;
    return v;
  endfunction

  always @(posedge clk) begin
    if (mem_wen) mem[mem_idx(mem_addr)] <= mem_din;
    mem_dout <= rd_val(mem_addr, mem_wen ? mem_din : mem[mem_idx(mem_addr)]);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a load and follow it until done (bounded) or until abort_after
  // writes have been seen. Sample index c counts edges after the start edge.
  task automatic run_load(input logic [LW-1:0] layer, input int nn, input int ni,
                          input logic verify, input int mode,
                          input logic [31:0] base, input int abort_after);
    int k;
    int c;
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    acc_cyc.delete();
    done_cyc = -1;
    done_cnt = 0;
    rdy_cnt  = 0;
    k = 0;
    cfg_layer       = layer;
    cfg_num_neurons = (NW + 1)'(nn);
    cfg_num_inputs  = (WAW + 1)'(ni);
    cfg_verify      = verify;
    start = 1'b1;
    tick();
    start = 1'b0;
    c = 0;
    s_valid = (mode == 0) || (c % 3 == 0);
    s_data  = base + 32'(k);
    while (c < 200) begin
      if (mem_wen) begin
        wr_addr.push_back(mem_addr);
        wr_data.push_back(mem_din);
        wr_cyc.push_back(c);
        if (abort_after > 0 && wr_addr.size() == abort_after) break;
      end
      if (s_ready) rdy_cnt++;
      if (done) begin
        done_cyc = c;
        done_cnt++;
        break;
      end
      if (s_valid && s_ready) begin
        k++;
        acc_cyc.push_back(c + 1);
      end
      tick();
      c++;
      s_valid = (mode == 0) || (c % 3 == 0);
      s_data  = base + 32'(k);
    end
    s_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctrl", {59'd0, mem_wen, s_ready, busy, done, err}, 64'd0);
    check("rst_addr", mem_addr, 0);
    check("rst_din", mem_din, 0);
    check("rst_err_addr", err_addr, 0);
    rst = 1'b0;
    tick();

    // Basic load, verify off, s_valid always high
    run_load(4'd1, 2, 3, 1'b0, 0, 32'hA0, 0);
    check("basic_count", wr_addr.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < wr_addr.size()) begin
        check($sformatf("basic_addr%0d", i), wr_addr[i], exp_addr[i]);
        check($sformatf("basic_data%0d", i), wr_data[i], 32'hA0 + 32'(i));
        check($sformatf("basic_cyc%0d", i), wr_cyc[i], i + 1);
      end
    end
    check("basic_done_cyc", done_cyc, 7);
    check("basic_err", err, 0);
    tick();
    check("basic_idle", {62'd0, busy, done}, 64'd0);

    // Backpressure: s_valid 1,0,0,1,...
    run_load(4'd1, 2, 3, 1'b0, 1, 32'hC0, 0);
    check("bp_count", wr_addr.size(), 6);
    check("bp_acc_count", acc_cyc.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < wr_addr.size() && i < acc_cyc.size()) begin
        check($sformatf("bp_addr%0d", i), wr_addr[i], exp_addr[i]);
        check($sformatf("bp_data%0d", i), wr_data[i], 32'hC0 + 32'(i));
        check($sformatf("bp_after_acc%0d", i), wr_cyc[i], acc_cyc[i]);
        check($sformatf("bp_cyc%0d", i), wr_cyc[i], 1 + 3 * i);
      end
    end
    check("bp_done_cyc", done_cyc, 17);
    tick();

    // Verify on, ideal memory
    corrupt_en = 1'b0;
    run_load(4'd1, 2, 3, 1'b1, 0, 32'h11, 0);
    check("vok_count", wr_addr.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < wr_addr.size()) begin
        check($sformatf("vok_addr%0d", i), wr_addr[i], exp_addr[i]);
        check($sformatf("vok_cyc%0d", i), wr_cyc[i], 1 + 3 * i);
      end
    end
    check("vok_ready_cycles", rdy_cnt, 6);
    check("vok_done_cyc", done_cyc, 18);
    check("vok_err", err, 0);
    tick();

    // Verify on, 4th and 5th words read back corrupted
    corrupt_en = 1'b1;
    run_load(4'd1, 2, 3, 1'b1, 0, 32'h20, 0);
    check("vbad_count", wr_addr.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < wr_addr.size()) begin
        check($sformatf("vbad_addr%0d", i), wr_addr[i], exp_addr[i]);
        check($sformatf("vbad_data%0d", i), wr_data[i], 32'h20 + 32'(i));
      end
    end
    check("vbad_done_cyc", done_cyc, 18);
    check("vbad_err", err, 1);
    check("vbad_err_addr", err_addr, 32'h1000_0400);
    tick();
    corrupt_en = 1'b0;
    check("vbad_err_sticky", err, 1);

    // Zero-size load; its start also clears the sticky error
    run_load(4'd1, 2, 0, 1'b0, 0, 32'h0, 0);
    check("zero_writes", wr_addr.size(), 0);
    check("zero_ready", rdy_cnt, 0);
    check("zero_done_cyc", done_cyc, 1);
    check("zero_err_cleared", err, 0);
    check("zero_err_addr_cleared", err_addr, 0);
    tick();

    // Reset after the 2nd write
    run_load(4'd1, 2, 3, 1'b0, 0, 32'h30, 2);
    check("abort_writes", wr_addr.size(), 2);
    rst = 1'b1;
    #1;
    check("abort_ctrl", {59'd0, mem_wen, s_ready, busy, done, err}, 64'd0);
    check("abort_addr", mem_addr, 0);
    check("abort_din", mem_din, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("abort_quiet%0d", i), {61'd0, mem_wen, busy, done}, 64'd0);
    end
    run_load(4'd1, 2, 3, 1'b0, 0, 32'h40, 0);
    check("restart_count", wr_addr.size(), 6);
    if (wr_addr.size() > 0) begin
      check("restart_addr0", wr_addr[0], 32'h1000_0000);
      check("restart_data0", wr_data[0], 32'h40);
    end
    check("restart_done_cyc", done_cyc, 7);
    check("restart_done_cnt", done_cnt, 1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
